// File: rtl/id_ex_stage_reg.sv
// ID/EX stage register: valid bit, hold, flush and load-use bubble insertion.
// Optional saturating bubble/flush counters when STAGE_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CTRL_W     = 10,
   parameter int MEMREN_BIT = 7,
   parameter int CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic [DATA_W-1:0]     id_rs_val,
   input  logic [DATA_W-1:0]     id_rt_val,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_rt_used,
   input  logic [REG_ADDR_W-1:0] id_dst_addr,
   input  logic                  ex_hold,
   input  logic                  flush,
   output logic                  ex_valid,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [DATA_W-1:0]     ex_rs_val,
   output logic [DATA_W-1:0]     ex_rt_val,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs_addr,
   output logic [REG_ADDR_W-1:0] ex_rt_addr,
   output logic [REG_ADDR_W-1:0] ex_dst_addr,
   output logic                  hazard_stall,
   output logic [CNT_W-1:0]      bubble_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   logic                  valid_q, valid_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
   logic [DATA_W-1:0]     rs_val_q, rs_val_d;
   logic [DATA_W-1:0]     rt_val_q, rt_val_d;
   logic [DATA_W-1:0]     imm_q, imm_d;
   logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
   logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
   logic [REG_ADDR_W-1:0] dst_addr_q, dst_addr_d;

   logic lu;
   logic rs_hit;
   logic rt_hit;
   logic load_fields;

   // A load in EX whose result the ID instruction needs next cycle.
   assign rs_hit = (dst_addr_q == id_rs_addr);
   assign rt_hit = id_rt_used & (dst_addr_q == id_rt_addr);

   assign lu = valid_q & ctrl_q[MEMREN_BIT] & (dst_addr_q != '0)
             & id_valid & (rs_hit | rt_hit);

   assign hazard_stall = lu & ~flush & ~ex_hold;

   always_comb begin
      valid_d     = valid_q;
      ctrl_d      = ctrl_q;
      load_fields = 1'b0;
      if (flush) begin
         valid_d     = 1'b0;
         ctrl_d      = '0;
         load_fields = 1'b1;
      end else if (ex_hold) begin
         valid_d = valid_q;
         ctrl_d  = ctrl_q;
      end else if (lu) begin
         // Bubble: payload stays put, ID re-presents next cycle.
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else begin
         valid_d     = id_valid;
         ctrl_d      = id_valid ? id_ctrl : '0;
         load_fields = 1'b1;
      end
   end

   always_comb begin
      rs_val_d   = rs_val_q;
      rt_val_d   = rt_val_q;
      imm_d      = imm_q;
      rs_addr_d  = rs_addr_q;
      rt_addr_d  = rt_addr_q;
      dst_addr_d = dst_addr_q;
      if (load_fields) begin
         rs_val_d   = id_rs_val;
         rt_val_d   = id_rt_val;
         imm_d      = id_imm;
         rs_addr_d  = id_rs_addr;
         rt_addr_d  = id_rt_addr;
         dst_addr_d = id_dst_addr;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q    <= 1'b0;
         ctrl_q     <= '0;
         rs_val_q   <= '0;
         rt_val_q   <= '0;
         imm_q      <= '0;
         rs_addr_q  <= '0;
         rt_addr_q  <= '0;
         dst_addr_q <= '0;
      end else begin
         valid_q    <= valid_d;
         ctrl_q     <= ctrl_d;
         rs_val_q   <= rs_val_d;
         rt_val_q   <= rt_val_d;
         imm_q      <= imm_d;
         rs_addr_q  <= rs_addr_d;
         rt_addr_q  <= rt_addr_d;
         dst_addr_q <= dst_addr_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_ctrl     = ctrl_q;
   assign ex_rs_val   = rs_val_q;
   assign ex_rt_val   = rt_val_q;
   assign ex_imm      = imm_q;
   assign ex_rs_addr  = rs_addr_q;
   assign ex_rt_addr  = rt_addr_q;
   assign ex_dst_addr = dst_addr_q;

`ifdef STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             bubble_fire;
   logic             flush_fire;

   assign bubble_fire = lu & ~flush & ~ex_hold;
   assign flush_fire  = flush & id_valid;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (bubble_fire && !(&bubble_cnt_q))
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (flush_fire && !(&flush_cnt_q))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`else
   assign bubble_cnt = '0;
   assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: stimulus pushes expectations,
// a monitor pops and compares hazard_stall mid-cycle and EX outputs after the edge.
module tb_id_ex_stage_reg;

`ifdef STAGE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        id_valid;
   logic [9:0]  id_ctrl;
   logic [31:0] id_rs_val;
   logic [31:0] id_rt_val;
   logic [31:0] id_imm;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic        id_rt_used;
   logic [4:0]  id_dst_addr;
   logic        ex_hold;
   logic        flush;
   logic        ex_valid;
   logic [9:0]  ex_ctrl;
   logic [31:0] ex_rs_val;
   logic [31:0] ex_rt_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs_addr;
   logic [4:0]  ex_rt_addr;
   logic [4:0]  ex_dst_addr;
   logic        hazard_stall;
   logic [15:0] bubble_cnt;
   logic [15:0] flush_cnt;

   id_ex_stage_reg dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .id_imm(id_imm), .id_rs_addr(id_rs_addr),
      .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
      .id_dst_addr(id_dst_addr), .ex_hold(ex_hold),
      .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_imm(ex_imm), .ex_rs_addr(ex_rs_addr),
      .ex_rt_addr(ex_rt_addr), .ex_dst_addr(ex_dst_addr),
      .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt),
      .flush_cnt(flush_cnt)
   );

   typedef struct {
      string       name;
      logic        hz;
      logic        valid;
      logic [9:0]  ctrl;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  rsa;
      logic [4:0]  rta;
      logic [4:0]  dst;
      int          bc;
      int          fc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   done   = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(
      input string nm,
      input logic v, input logic [9:0] c,
      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
      input logic [4:0] rsa, input logic [4:0] rta, input logic rtu,
      input logic [4:0] dst, input logic hold, input logic fl,
      input logic ehz, input logic ev, input logic [9:0] ec,
      input logic [31:0] ers, input logic [31:0] ert, input logic [31:0] eimm,
      input logic [4:0] ersa, input logic [4:0] erta, input logic [4:0] edst,
      input int ebc, input int efc);
      exp_t e;
      @(posedge clock);
      #2;
      id_valid = v; id_ctrl = c; id_rs_val = rs; id_rt_val = rt;
      id_imm = imm; id_rs_addr = rsa; id_rt_addr = rta;
      id_rt_used = rtu; id_dst_addr = dst; ex_hold = hold; flush = fl;
      e.name = nm; e.hz = ehz; e.valid = ev; e.ctrl = ec;
      e.rs = ers; e.rt = ert; e.imm = eimm;
      e.rsa = ersa; e.rta = erta; e.dst = edst;
      e.bc = PERF ? ebc : 0;
      e.fc = PERF ? efc : 0;
      sb.push_back(e);
   endtask

   // Monitor: hazard_stall mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, ".hz"}, {31'd0, hazard_stall}, {31'd0, e.hz});
            @(posedge clock);
            #1;
            check({e.name, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
            check({e.name, ".ctrl"}, {22'd0, ex_ctrl}, {22'd0, e.ctrl});
            check({e.name, ".rs"}, ex_rs_val, e.rs);
            check({e.name, ".rt"}, ex_rt_val, e.rt);
            check({e.name, ".imm"}, ex_imm, e.imm);
            check({e.name, ".rsa"}, {27'd0, ex_rs_addr}, {27'd0, e.rsa});
            check({e.name, ".rta"}, {27'd0, ex_rt_addr}, {27'd0, e.rta});
            check({e.name, ".dst"}, {27'd0, ex_dst_addr}, {27'd0, e.dst});
            check({e.name, ".bcnt"}, {16'd0, bubble_cnt}, e.bc);
            check({e.name, ".fcnt"}, {16'd0, flush_cnt}, e.fc);
         end
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1, "watchdog");
      end
   end

   initial begin
      reset = 1'b1;
      id_valid = 0; id_ctrl = '0; id_rs_val = '0; id_rt_val = '0;
      id_imm = '0; id_rs_addr = '0; id_rt_addr = '0; id_rt_used = 0;
      id_dst_addr = '0; ex_hold = 0; flush = 0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("rst.valid", {31'd0, ex_valid}, 32'd0);
      check("rst.ctrl", {22'd0, ex_ctrl}, 32'd0);
      check("rst.rs", ex_rs_val, 32'd0);
      check("rst.hz", {31'd0, hazard_stall}, 32'd0);

      step("pass", 1, 10'h041, 32'hDEADBEEF, 32'h12345678, 32'hFF, 1, 2, 1, 3, 0, 0,
           0, 1, 10'h041, 32'hDEADBEEF, 32'h12345678, 32'hFF, 1, 2, 3, 0, 0);
      step("lw8", 1, 10'h0C0, 32'h100, 32'h0, 32'h4, 29, 8, 0, 8, 0, 0,
           0, 1, 10'h0C0, 32'h100, 32'h0, 32'h4, 29, 8, 8, 0, 0);
      step("lu_rs", 1, 10'h041, 32'h11, 32'h22, 32'h0, 8, 9, 1, 10, 0, 0,
           1, 0, 10'h000, 32'h100, 32'h0, 32'h4, 29, 8, 8, 1, 0);
      step("lu_rel", 1, 10'h041, 32'h11, 32'h22, 32'h0, 8, 9, 1, 10, 0, 0,
           0, 1, 10'h041, 32'h11, 32'h22, 32'h0, 8, 9, 10, 1, 0);
      step("lw0", 1, 10'h0C0, 32'h5, 32'h6, 32'h8, 4, 0, 0, 0, 0, 0,
           0, 1, 10'h0C0, 32'h5, 32'h6, 32'h8, 4, 0, 0, 1, 0);
      step("dep0", 1, 10'h041, 32'h7, 32'h9, 32'h1, 0, 0, 1, 11, 0, 0,
           0, 1, 10'h041, 32'h7, 32'h9, 32'h1, 0, 0, 11, 1, 0);
      step("lw8b", 1, 10'h0C0, 32'hA, 32'hB, 32'hC, 5, 8, 0, 8, 0, 0,
           0, 1, 10'h0C0, 32'hA, 32'hB, 32'hC, 5, 8, 8, 1, 0);
      step("rt_unused", 1, 10'h041, 32'h1, 32'h2, 32'h3, 3, 8, 0, 12, 0, 0,
           0, 1, 10'h041, 32'h1, 32'h2, 32'h3, 3, 8, 12, 1, 0);
      step("lw8c", 1, 10'h0C0, 32'h20, 32'h21, 32'h22, 6, 8, 0, 8, 0, 0,
           0, 1, 10'h0C0, 32'h20, 32'h21, 32'h22, 6, 8, 8, 1, 0);
      step("lu_rt", 1, 10'h041, 32'h30, 32'h31, 32'h32, 2, 8, 1, 13, 0, 0,
           1, 0, 10'h000, 32'h20, 32'h21, 32'h22, 6, 8, 8, 2, 0);
      step("lu_rt_rel", 1, 10'h041, 32'h30, 32'h31, 32'h32, 2, 8, 1, 13, 0, 0,
           0, 1, 10'h041, 32'h30, 32'h31, 32'h32, 2, 8, 13, 2, 0);
      step("hold1", 1, 10'h3FF, 32'hAAAA, 32'hBBBB, 32'hCCCC, 7, 7, 1, 7, 1, 0,
           0, 1, 10'h041, 32'h30, 32'h31, 32'h32, 2, 8, 13, 2, 0);
      step("hold2", 0, 10'h155, 32'h1111, 32'h2222, 32'h3333, 9, 10, 0, 11, 1, 0,
           0, 1, 10'h041, 32'h30, 32'h31, 32'h32, 2, 8, 13, 2, 0);
      step("hold3", 1, 10'h0C0, 32'hFFFF, 32'hEEEE, 32'hDDDD, 13, 13, 1, 13, 1, 0,
           0, 1, 10'h041, 32'h30, 32'h31, 32'h32, 2, 8, 13, 2, 0);
      step("flush_hold", 1, 10'h155, 32'h40, 32'h41, 32'h42, 14, 15, 1, 16, 1, 1,
           0, 0, 10'h000, 32'h40, 32'h41, 32'h42, 14, 15, 16, 2, 1);
      step("lw17", 1, 10'h0C0, 32'h50, 32'h51, 32'h52, 1, 2, 0, 17, 0, 0,
           0, 1, 10'h0C0, 32'h50, 32'h51, 32'h52, 1, 2, 17, 2, 1);
      step("flush_lu", 1, 10'h041, 32'h60, 32'h61, 32'h62, 17, 0, 1, 18, 0, 1,
           0, 0, 10'h000, 32'h60, 32'h61, 32'h62, 17, 0, 18, 2, 2);
      step("idle", 0, 10'h3FF, 32'h70, 32'h71, 32'h72, 1, 1, 1, 1, 0, 0,
           0, 0, 10'h000, 32'h70, 32'h71, 32'h72, 1, 1, 1, 2, 2);
      step("full", 1, 10'h3FF, 32'h80, 32'h81, 32'h82, 3, 4, 1, 5, 0, 0,
           0, 1, 10'h3FF, 32'h80, 32'h81, 32'h82, 3, 4, 5, 2, 2);

      // Mid-stream reset while EX holds a load and ID depends on it.
      @(posedge clock);
      #2;
      id_valid = 1; id_ctrl = 10'h041; id_rs_addr = 5; id_rt_used = 0;
      ex_hold = 0; flush = 0;
      #1;
      check("pre_rst.hz", {31'd0, hazard_stall}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst.valid", {31'd0, ex_valid}, 32'd0);
      check("mid_rst.ctrl", {22'd0, ex_ctrl}, 32'd0);
      check("mid_rst.rs", ex_rs_val, 32'd0);
      check("mid_rst.rt", ex_rt_val, 32'd0);
      check("mid_rst.imm", ex_imm, 32'd0);
      check("mid_rst.dst", {27'd0, ex_dst_addr}, 32'd0);
      check("mid_rst.hz", {31'd0, hazard_stall}, 32'd0);
      check("mid_rst.bcnt", {16'd0, bubble_cnt}, 32'd0);
      check("mid_rst.fcnt", {16'd0, flush_cnt}, 32'd0);
      repeat (2) @(posedge clock);
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
